// File: rtl/regfile_dump.sv
// regfile_dump
//   Debug read-out engine for the processor register file. A start pulse in
//   IDLE walks the register file's read port from x0 to x(NREGS-1). Each
//   value is captured in its own FETCH cycle and then offered as an
//   index/data beat on a valid/ready stream. A running XOR of every accepted
//   beat is kept and held until the next start.
//
// Parameters
//   WIDTH      register data width (must match the register file)
//   NREGS      number of registers dumped, starting at x0 (1..32)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a dump (only honoured in IDLE)
//   busy       high from the cycle after start is accepted through DONE
//   rd_addr    register file read address
//   rd_data    combinational read data for rd_addr
//   out_valid  beat available
//   out_ready  consumer accepts the beat when out_valid & out_ready at an edge
//   out_index  register number of the current beat
//   out_data   captured register value
//   out_last   high with the beat for index NREGS-1
//   done       one-cycle pulse after the last beat is accepted
//   checksum   XOR of all accepted beats of the current or most recent dump
module regfile_dump #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [4:0]       rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_index,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic [WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } stateT;

  localparam logic [4:0] LastIdx = 5'(NREGS - 1);

  stateT      state;
  logic [4:0] idx;

  // All outputs are registered and updated together with the state, so each
  // output's next value is written in the branch that enters the state where
  // it must hold.
  // NOTE: every register here is assigned with <= so that all of them see the
  // pre-edge values of each other (e.g. checksum reads the old out_data).
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset is asynchronous, so a reset mid-dump clears the stream
    // immediately without waiting for a clock edge and no done is produced.
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            idx      <= '0;
            checksum <= '0;
            busy     <= 1'b1;
            rd_addr  <= '0;
          end
        end

        // The read port has been presenting idx for this whole cycle; the
        // value captured here is the snapshot of that register.
        FETCH: begin
          out_data  <= rd_data;
          out_index <= idx;
          out_last  <= (idx == LastIdx);
          out_valid <= 1'b1;
          state     <= SEND;
        end

        // Beat is held unchanged until the consumer takes it.
        SEND: begin
          if (out_ready) begin
            checksum  <= checksum ^ out_data;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == LastIdx) begin
              state   <= DONE;
              done    <= 1'b1;
              rd_addr <= '0;
            end else begin
              idx     <= idx + 5'd1;
              rd_addr <= idx + 5'd1;
              state   <= FETCH;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump
//   Self-checking bench for regfile_dump. Two instances share one register
//   file model: one dumping 32 registers, one dumping 4. A select bit routes
//   start to one instance and its outputs to the common observation nets.
//   Expected beats come from a snapshot of the register array taken before
//   each dump; expected timing from 2*N+1 plus the number of stalled cycles.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        clkEn = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        outReady = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] regs [32];

  int numChecks = 0;
  int numErrors = 0;

  always #5 if (clkEn) clk = ~clk;

  // Instance with NREGS=32
  logic        busy32, valid32, last32, done32;
  logic [4:0]  rdAddr32, index32;
  logic [31:0] rdData32, data32, sum32;
  // Instance with NREGS=4
  logic        busy4, valid4, last4, done4;
  logic [4:0]  rdAddr4, index4;
  logic [31:0] rdData4, data4, sum4;

  assign rdData32 = regs[rdAddr32];
  assign rdData4  = regs[rdAddr4];

  regfile_dump #(.WIDTH(32), .NREGS(32)) dut32 (
    .clk(clk), .rst(rst), .start(start & ~sel), .busy(busy32),
    .rd_addr(rdAddr32), .rd_data(rdData32), .out_valid(valid32),
    .out_ready(outReady), .out_index(index32), .out_data(data32),
    .out_last(last32), .done(done32), .checksum(sum32)
  );

  regfile_dump #(.WIDTH(32), .NREGS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start & sel), .busy(busy4),
    .rd_addr(rdAddr4), .rd_data(rdData4), .out_valid(valid4),
    .out_ready(outReady), .out_index(index4), .out_data(data4),
    .out_last(last4), .done(done4), .checksum(sum4)
  );

  // Observation nets for whichever instance is selected
  logic        busy, outValid, outLast, done;
  logic [4:0]  rdAddr, outIndex;
  logic [31:0] outData, checksum;

  assign busy     = sel ? busy4   : busy32;
  assign outValid = sel ? valid4  : valid32;
  assign outLast  = sel ? last4   : last32;
  assign done     = sel ? done4   : done32;
  assign rdAddr   = sel ? rdAddr4 : rdAddr32;
  assign outIndex = sel ? index4  : index32;
  assign outData  = sel ? data4   : data32;
  assign checksum = sel ? sum4    : sum32;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one dump on the selected instance and checks every beat, the
  // done timing and the checksum. Optional behaviours: a fixed stall on one
  // beat, random ready, start pokes while busy, and the snapshot writes.
  task automatic doDump(input string tag, input int n, input int stallIdx,
                        input int stallLen, input bit randReady,
                        input bit pokeStart, input bit snapWrite);
    logic [31:0] expArr [32];
    logic [31:0] expSum;
    int  cyc, beat, stalls, stallCnt, dones, budget;
    bit  wrote, seenValid;

    for (int i = 0; i < 32; i++) expArr[i] = regs[i];
    // x3 is rewritten before its FETCH (reflected); x1 after its FETCH (not)
    if (snapWrite) expArr[3] = 32'hA5A5A5A5;
    expSum = '0;
    for (int i = 0; i < n; i++) expSum ^= expArr[i];

    outReady = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;

    cyc = 1; beat = 0; stalls = 0; stallCnt = 0; dones = 0;
    wrote = 1'b0; seenValid = 1'b0;
    budget = 2 * n + 1 + 400;

    while (dones == 0 && cyc < budget) begin
      check({tag, "/busy"}, 32'(busy), 32'd1);
      if (outValid) begin
        if (!seenValid) begin
          check({tag, "/latency"}, 32'(cyc), 32'd2);
          seenValid = 1'b1;
        end
        check({tag, "/index"}, 32'(outIndex), 32'(beat));
        check({tag, "/data"}, outData, (beat < n) ? expArr[beat] : 32'hXXXX_XXXX);
        check({tag, "/last"}, 32'(outLast), 32'(beat == n - 1));
        check({tag, "/rd_addr"}, 32'(rdAddr), 32'(beat));
        start = pokeStart && (beat == 3 || beat == 20);
        if (snapWrite && beat == 1 && !wrote) begin
          regs[3] = 32'hA5A5A5A5;
          regs[1] = 32'hFFFFFFFF;
          wrote = 1'b1;
        end
        if (randReady) outReady = 1'($urandom_range(0, 1));
        else outReady = !(beat == stallIdx && stallCnt < stallLen);
        if (!outReady) begin
          stalls++;
          if (beat == stallIdx) stallCnt++;
        end else begin
          beat++;
        end
      end else begin
        start = 1'b0;
        outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done) begin
        dones++;
        check({tag, "/done_cycle"}, 32'(cyc), 32'(2 * n + 1 + stalls));
        check({tag, "/beats"}, 32'(beat), 32'(n));
        check({tag, "/checksum"}, checksum, expSum);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    outReady = 1'b1;
    check({tag, "/done_seen"}, 32'(dones), 32'd1);

    // Back in IDLE: nothing active, checksum held, no second done
    for (int k = 0; k < 3; k++) begin
      check({tag, "/idle_quiet"}, {29'd0, busy, outValid, done}, 32'd0);
      check({tag, "/sum_held"}, checksum, expSum);
      tick();
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    // Reset with the clock stopped: outputs clear at once
    sel = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst/ctl", {28'd0, busy, outValid, outLast, done}, 32'd0);
    check("rst/rd_addr", 32'(rdAddr), 32'd0);
    check("rst/index", 32'(outIndex), 32'd0);
    check("rst/data", outData, 32'd0);
    check("rst/checksum", checksum, 32'd0);
    #2 rst = 1'b0;
    clkEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle/no_activity", {29'd0, busy, outValid, done}, 32'd0);
    end

    // Full dump, ready high
    regs[5] = 32'hDEADBEEF;
    regs[31] = 32'h00000001;
    doDump("full", 32, -1, 0, 1'b0, 1'b0, 1'b0);
    check("full/sum_value", checksum, 32'hDEADBEEE);

    // Backpressure on beat 7
    regs[7] = 32'h12345678;
    doDump("bp", 32, 7, 3, 1'b0, 1'b0, 1'b0);

    // Start pulses while busy are ignored
    doDump("busy_start", 32, -1, 0, 1'b0, 1'b1, 1'b0);

    // Reset during SEND of beat 10
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(outValid && outIndex == 5'd10) && k < 100) begin
      tick();
      k++;
    end
    check("midrst/reached_beat10", 32'(k < 100), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst/valid", 32'(outValid), 32'd0);
    check("midrst/checksum", checksum, 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst/no_done", {30'd0, busy, done}, 32'd0);
    end
    doDump("after_rst", 32, -1, 0, 1'b0, 1'b0, 1'b0);

    // Random contents and random ready on both instances
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      doDump("rand32", 32, -1, 0, 1'b1, 1'b0, 1'b0);
    end
    sel = 1'b1;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      doDump("rand4", 4, -1, 0, 1'b1, 1'b0, 1'b0);
    end

    // Snapshot rule on the 4-register instance
    regs[0] = 32'h0;
    regs[1] = 32'h11111111;
    regs[2] = 32'h22222222;
    regs[3] = 32'h33333333;
    doDump("snap4", 4, -1, 0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the 32-entry processor register file. On a start pulse it walks the register file's read port from x0 to x(NREGS-1), captures each value, and streams it out as an index/data beat over a valid/ready handshake. It keeps a running XOR checksum of all emitted values. It sits beside the register file on a spare read port (or a debug-muxed AddrB) and feeds a debug/trace link.

## Interface
- WIDTH, 32, register data width; must match the register file.
- NREGS, 32, number of registers dumped, starting at x0; legal range 1..32.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin dump; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- rd_addr  out  5  register file read address.
- rd_data  in  WIDTH  combinational read data returned for rd_addr.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready at a rising edge.
- out_index  out  5  register number of the current beat.
- out_data  out  WIDTH  captured register value.
- out_last  out  1  high with the beat for index NREGS-1.
- done  out  1  one-cycle pulse after the last beat is accepted.
- checksum  out  WIDTH  XOR of all accepted beats in the current or most recent dump; held until the next start.

## Operation
- FSM states: IDLE, FETCH, SEND, DONE. idx is a 5-bit counter.
- IDLE: busy=0, out_valid=0, rd_addr=0. If start=1, go to FETCH with idx←0 and checksum←0.
- FETCH (one cycle): rd_addr=idx. At the edge, out_data←rd_data and out_index←idx, then go to SEND.
- SEND: out_valid=1, and rd_addr stays at idx. out_data, out_index and out_last hold stable until accepted.
  - On accept: checksum←checksum^out_data.
  - If idx==NREGS-1, go to DONE.
  - Otherwise idx←idx+1 and go to FETCH.
- DONE (one cycle): done=1, out_valid=0. Then go to IDLE.
- out_last = (state==SEND) & (idx==NREGS-1).
- Snapshot rule: each value is sampled in its own FETCH cycle.
  - Writes to a register after its FETCH are not reflected.
  - Writes before its FETCH are reflected.
- x0 is emitted as whatever the register file returns (0 in a correct design). No special-casing.
- start in FETCH, SEND or DONE is ignored. It is not queued.
- out_valid never drops without an accept, except on reset.
- The checksum is XOR only; there is no carry.

## Timing
- Reset (asynchronous, immediate) forces state=IDLE and idx=0. It also drives busy, out_valid, out_last, done, rd_addr, out_index, out_data and checksum to 0.
- Reset mid-dump aborts immediately. No done pulse is produced, and a new start is required.
- Latency: start sampled at edge E gives FETCH in cycle E+1 and the first out_valid in cycle E+2.
- Each beat takes a minimum of 2 cycles: one FETCH and one SEND with ready high.
- With out_ready tied high, the full dump is 2·NREGS+1 cycles from start to done, counting the DONE cycle. For NREGS=32 that is 65 cycles.
- Each cycle out_ready is low in SEND adds one cycle.
- checksum is updated at the accept edge. Its final value is visible in the DONE cycle and is held through IDLE.
- The earliest new start is in the IDLE cycle right after DONE.

## Test plan
- Reset: assert rst mid-cycle with clk stopped -> all outputs 0 immediately. Release rst, then start=0 for 10 cycles -> no activity.
- Full dump, ready high:
  - Setup: preload x5=0xDEADBEEF and x31=0x00000001, all others 0, then pulse start.
  - Required: 32 beats with out_index 0..31 in order and out_data matching.
  - Required: out_last only with index 31, done exactly 65 cycles after start, checksum=0xDEADBEEE.
- Backpressure: hold out_ready low for 3 cycles on beat 7 (x7=0x12345678) -> out_valid, out_index=7 and out_data=0x12345678 are stable all 3 cycles. Beat 8 starts only after the accept, and the total is 68 cycles.
- Start while busy: pulse start during beats 3 and 20 -> single dump, 32 beats, one done pulse.
- Reset mid-dump: assert rst during the SEND of beat 10 -> out_valid=0 and checksum=0 immediately, and no done pulse. A fresh start then dumps from index 0.
- Snapshot and NREGS=4:
  - Setup: NREGS=4; write x3=0xA5A5A5A5 during the SEND of beat 1, then write x1=0xFFFFFFFF after its FETCH.
  - Required: beat 3 shows 0xA5A5A5A5, beat 1 shows the old value, done arrives 9 cycles after start, and out_last is on index 3.
